// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Brief    : Oversampled UART transmitter with a one-deep holding register.
//            Optional even parity bit enabled by defining UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int OVERSAMPLE  = 13,
  parameter int N_DATA_BITS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic [N_DATA_BITS-1:0] i_data,
  input  logic                   i_data_valid,
  output logic                   o_ready,
  output logic                   o_tx,
  output logic                   o_busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE) + 1;
  localparam int IDX_W  = $clog2(N_DATA_BITS) + 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                   state, state_n;
  logic [TICK_W-1:0]        tick, tick_n;
  logic [IDX_W-1:0]         idx, idx_n;
  logic [N_DATA_BITS-1:0]   shifter, shifter_n;
  logic [N_DATA_BITS-1:0]   holding, holding_n;
  logic                     hold_full, hold_full_n;
  logic                     tx_n;
  logic                     bit_end;
  logic                     load;
`ifdef UART_TX_PARITY_EN
  logic                     par, par_n;
`endif

  assign bit_end = (tick == TICK_LAST);
  assign o_ready = ~hold_full;
  assign o_busy  = (state != IDLE) | hold_full;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      tick      <= '0;
      idx       <= '0;
      shifter   <= '0;
      holding   <= '0;
      hold_full <= 1'b0;
      o_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      idx       <= idx_n;
      shifter   <= shifter_n;
      holding   <= holding_n;
      hold_full <= hold_full_n;
      o_tx      <= tx_n;
`ifdef UART_TX_PARITY_EN
      par       <= par_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    tick_n      = tick;
    idx_n       = idx;
    shifter_n   = shifter;
    holding_n   = holding;
    hold_full_n = hold_full;
    tx_n        = o_tx;
    load        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n       = par;
`endif

    // Handshake is independent of i_en; it can never coincide with a load
    // because a load requires the holding register to already be full.
    if (i_data_valid && !hold_full) begin
      holding_n   = i_data;
      hold_full_n = 1'b1;
    end

    if (i_en) begin
      case (state)
        IDLE:  load = hold_full;
        START: if (bit_end) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = shifter[0];
        end
        DATA: if (bit_end) begin
          if (idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = par;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            idx_n     = idx + IDX_W'(1);
            shifter_n = shifter >> 1;
            tx_n      = shifter_n[0];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (bit_end) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
`endif
        STOP: if (bit_end) begin
          if (hold_full) begin
            load = 1'b1;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase

      if (state != IDLE) begin
        tick_n = bit_end ? '0 : tick + TICK_W'(1);
      end
    end

    // Back-to-back frames reuse this path straight out of STOP.
    if (load) begin
      state_n     = START;
      tick_n      = '0;
      shifter_n   = holding;
      hold_full_n = 1'b0;
      tx_n        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_n       = ^holding;
`endif
    end
  end

endmodule
`default_nettype wire
